rf_writeback: RTL and testbench

Writeback stage directly upstream of the register file write port. It merges single-cycle ALU results and out-of-order-latency LSU results onto the one write port, and buffers LSU responses in a small FIFO. It keeps a per-register pending scoreboard so decode can stall on operands still owed by the LSU. Drives the register file's wen/waddr/wdata; sits between execute/LSU and the register file.

---
 rtl/rf_writeback_pkg.sv | 30 +++
 rtl/rf_wb_fifo.sv | 55 +++++
 rtl/rf_writeback.sv | 153 +++++++++++++++
 tb/tb_rf_writeback.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_writeback_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_pkg
//  Description : Shared constants and the buffered LSU response entry type
//                for the register-file writeback stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_writeback_pkg;

  // Default widths; the entry struct is sized from these, so the top-level
  // ADDR_WIDTH/DATA_WIDTH parameters are expected to keep these values.
  localparam int WB_ADDR_W   = 5;
  localparam int WB_DATA_W   = 32;
  localparam int WB_LQ_DEPTH = 4;

  // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
  function automatic int lq_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LQ_PTR_W = lq_ptr_w(WB_LQ_DEPTH);

  // One buffered LSU response.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_fifo
//  Description : Generic synchronous FIFO with wrap-bit pointers. Exposes the
//                head entry combinationally; push is refused when full and
//                pop is refused when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Full when the wrap bits differ and the index bits match.
  assign full      = (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]) &&
                     (r_wptr[PTR_W-2:0] == r_rptr[PTR_W-2:0]);
  assign empty     = (r_wptr == r_rptr);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head_data = r_mem[r_rptr[PTR_W-2:0]];

  // Pointer update; pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[PTR_W-2:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback
//  Description : Writeback stage feeding the register-file write port. Merges
//                ALU results (priority) with buffered LSU responses, tracks
//                registers still owed by the LSU, and raises alu_hold when a
//                buffered response has been starved for too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH   = WB_ADDR_W,
  parameter int DATA_WIDTH   = WB_DATA_W,
  parameter int LQ_DEPTH     = WB_LQ_DEPTH,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_hold,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic                  lsu_rsp_valid,
  output logic                  lsu_rsp_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rsp_rd,
  input  logic [DATA_WIDTH-1:0] lsu_rsp_data,
  input  logic [ADDR_WIDTH-1:0] q_raddr1,
  input  logic [ADDR_WIDTH-1:0] q_raddr2,
  output logic                  q_busy1,
  output logic                  q_busy2,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int c_PTR_W    = lq_ptr_w(LQ_DEPTH);
  localparam int c_ENTRY_W  = $bits(wb_entry_t);
  localparam int c_NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int c_STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

  wb_entry_t               w_push_entry;
  wb_entry_t               w_head;
  logic [c_ENTRY_W-1:0]    w_head_bits;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_alu_win;
  logic                    w_pop;
  logic [c_NUM_REGS-1:0]   w_pending_nxt;

  logic [c_NUM_REGS-1:0]   r_pending;
  logic                    r_rf_wen;
  logic [ADDR_WIDTH-1:0]   r_rf_waddr;
  logic [DATA_WIDTH-1:0]   r_rf_wdata;
  logic                    r_from_fifo;
  logic [c_STARVE_W-1:0]   r_starve;
  logic                    r_hold;

  assign w_push_entry = '{rd: lsu_rsp_rd, data: lsu_rsp_data};
  assign w_head       = wb_entry_t'(w_head_bits);

  rf_wb_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (LQ_DEPTH),
    .PTR_W (c_PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head_data (w_head_bits),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Ready follows registered full only, so a same-cycle pop never frees a slot.
  assign lsu_rsp_ready = !w_full;
  assign w_push        = lsu_rsp_valid && !w_full;

  // ALU owns the port unless it targets x0; otherwise the FIFO head drains.
  assign w_alu_win = alu_valid && (alu_rd != '0);
  assign w_pop     = !w_alu_win && !w_empty;

  assign iss_ready = !r_pending[iss_rd];
  assign q_busy1   = r_pending[q_raddr1] && (q_raddr1 != '0);
  assign q_busy2   = r_pending[q_raddr2] && (q_raddr2 != '0);

  assign rf_wen    = r_rf_wen;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;
  assign alu_hold  = r_hold;

  // Scoreboard next state: clear on the FIFO-sourced RF write, set on issue.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_rf_wen && r_from_fifo) w_pending_nxt[r_rf_waddr] = 1'b0;
    if (iss_valid && iss_ready && (iss_rd != '0)) w_pending_nxt[iss_rd] = 1'b1;
  end

  // Pending bits per architectural register.
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= w_pending_nxt;
  end

  // Register the winning write; address/data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_wen    <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_from_fifo <= 1'b0;
    end else if (w_alu_win) begin
      r_rf_wen    <= 1'b1;
      r_rf_waddr  <= alu_rd;
      r_rf_wdata  <= alu_data;
      r_from_fifo <= 1'b0;
    end else if (w_pop && (w_head.rd != '0)) begin
      r_rf_wen    <= 1'b1;
      r_rf_waddr  <= w_head.rd;
      r_rf_wdata  <= w_head.data;
      r_from_fifo <= 1'b1;
    end else begin
      // Idle cycle or a popped x0 entry: nothing reaches the register file.
      r_rf_wen    <= 1'b0;
      r_from_fifo <= 1'b0;
    end
  end

  // Starvation tracking: count ALU-blocked cycles, hold the ALU off once the
  // limit is seen, and release the cycle after the head finally drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
      r_hold   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_starve <= '0;
      end else if (!w_empty && w_alu_win && (r_starve != c_STARVE_MAX)) begin
        r_starve <= r_starve + 1'b1;
      end
      r_hold <= w_pop ? 1'b0 : (r_hold || (r_starve == c_STARVE_MAX));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_writeback
//  Description : Directed self-checking bench for rf_writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_hold;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        iss_ready;
  logic        lsu_rsp_valid = 1'b0;
  logic        lsu_rsp_ready;
  logic [4:0]  lsu_rsp_rd = '0;
  logic [31:0] lsu_rsp_data = '0;
  logic [4:0]  q_raddr1 = '0;
  logic [4:0]  q_raddr2 = '0;
  logic        q_busy1;
  logic        q_busy2;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_errors = 0;

  rf_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_hold      (alu_hold),
    .iss_valid     (iss_valid),
    .iss_rd        (iss_rd),
    .iss_ready     (iss_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rsp_rd    (lsu_rsp_rd),
    .lsu_rsp_data  (lsu_rsp_data),
    .q_raddr1      (q_raddr1),
    .q_raddr2      (q_raddr2),
    .q_busy1       (q_busy1),
    .q_busy2       (q_busy2),
    .rf_wen        (rf_wen),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag, input logic wen, input logic [4:0] addr,
                          input logic [31:0] data);
    check({tag, "_wen"}, rf_wen, wen);
    if (wen) begin
      check({tag, "_waddr"}, rf_waddr, addr);
      check({tag, "_wdata"}, rf_wdata, data);
    end
  endtask

  // Upstream protocol: no ALU op while held, no ALU write to a pending register.
  always @(negedge clk) begin
    if (!rst && alu_valid) begin
      check("proto_alu_during_hold", alu_hold, 1'b0);
      check("proto_alu_waw", dut.r_pending[alu_rd] && (alu_rd != 5'd0), 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset and idle ----------------
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_wen", rf_wen, 1'b0);
    check("rst_waddr", rf_waddr, 5'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_hold", alu_hold, 1'b0);
    check("rst_ready", lsu_rsp_ready, 1'b1);
    for (int a = 0; a < 32; a++) begin
      q_raddr1 = 5'(a);
      q_raddr2 = 5'(31 - a);
      iss_rd   = 5'(a);
      #1;
      check("idle_busy1", q_busy1, 1'b0);
      check("idle_busy2", q_busy2, 1'b0);
      check("idle_iss_ready", iss_ready, 1'b1);
      step();
    end

    // ---------------- ALU write and x0 drop ----------------
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_rd = 5'd0; alu_data = 32'h55555555;
    #1;
    check_rf("alu_r5", 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    alu_valid = 1'b0;
    check("alu_x0_wen", rf_wen, 1'b0);
    check("alu_x0_waddr_hold", rf_waddr, 5'd5);
    check("alu_x0_wdata_hold", rf_wdata, 32'hDEADBEEF);

    // ---------------- issue + LSU response ----------------
    iss_valid = 1'b1; iss_rd = 5'd7; q_raddr1 = 5'd7; q_raddr2 = 5'd0;
    #1;
    check("iss7_ready_before", iss_ready, 1'b1);
    check("iss7_busy_before", q_busy1, 1'b0);
    step();
    iss_valid = 1'b0;
    #1;
    check("iss7_busy", q_busy1, 1'b1);
    check("iss7_ready_after", iss_ready, 1'b0);
    check("x0_busy", q_busy2, 1'b0);
    lsu_rsp_valid = 1'b1; lsu_rsp_rd = 5'd7; lsu_rsp_data = 32'h1234;
    step();                                   // pushed; head pops this cycle
    lsu_rsp_valid = 1'b0;
    #1;
    check("lsu7_wen_p1", rf_wen, 1'b0);
    check("lsu7_busy_p1", q_busy1, 1'b1);
    step();                                   // push + 2: RF write visible
    check_rf("lsu7_p2", 1'b1, 5'd7, 32'h1234);
    check("lsu7_busy_p2", q_busy1, 1'b1);
    step();
    check("lsu7_busy_p3", q_busy1, 1'b0);
    check("lsu7_ready_p3", iss_ready, 1'b1);
    check("lsu7_wen_p3", rf_wen, 1'b0);

    // ---------------- fill FIFO under constant ALU traffic ----------------
    for (int k = 0; k < 5; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(k + 1); alu_data = 32'hA000 + 32'(k);
      lsu_rsp_valid = 1'b1; lsu_rsp_rd = 5'(20 + k); lsu_rsp_data = 32'h100 + 32'(k);
      #1;
      check("fill_ready", lsu_rsp_ready, (k < 4) ? 1'b1 : 1'b0);
      check("fill_hold", alu_hold, 1'b0);
      if (k > 0) check_rf("fill_alu", 1'b1, 5'(k), 32'hA000 + 32'(k - 1));
      step();
    end
    alu_valid = 1'b0; lsu_rsp_valid = 1'b0;
    #1;
    check("starve_hold", alu_hold, 1'b1);
    check("starve_ready", lsu_rsp_ready, 1'b0);
    check_rf("starve_alu5", 1'b1, 5'd5, 32'hA004);
    step();
    check("drain_hold_clear", alu_hold, 1'b0);
    check("drain_ready", lsu_rsp_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check_rf("drain_order", 1'b1, 5'(20 + k), 32'h100 + 32'(k));
      step();
    end
    check("drain_no_extra", rf_wen, 1'b0);

    // ---------------- ALU vs FIFO head collision ----------------
    lsu_rsp_valid = 1'b1; lsu_rsp_rd = 5'd9; lsu_rsp_data = 32'h99;
    step();
    lsu_rsp_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    step();
    alu_valid = 1'b0;
    #1;
    check_rf("coll_alu3", 1'b1, 5'd3, 32'h33);
    step();
    check_rf("coll_lsu9", 1'b1, 5'd9, 32'h99);
    step();
    check("coll_idle", rf_wen, 1'b0);

    // ---------------- reset with buffered state ----------------
    iss_valid = 1'b1; iss_rd = 5'd7;
    lsu_rsp_valid = 1'b1; lsu_rsp_rd = 5'd7; lsu_rsp_data = 32'h77;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    step();
    iss_valid = 1'b0;
    lsu_rsp_rd = 5'd12; lsu_rsp_data = 32'hCC;
    alu_rd = 5'd2; alu_data = 32'h22;
    step();
    lsu_rsp_valid = 1'b0; alu_valid = 1'b0;
    q_raddr1 = 5'd7;
    rst = 1'b1;
    #1;
    check("pre_rst_busy7", q_busy1, 1'b1);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_busy7", q_busy1, 1'b0);
    check("post_rst_wen", rf_wen, 1'b0);
    check("post_rst_hold", alu_hold, 1'b0);
    check("post_rst_ready", lsu_rsp_ready, 1'b1);
    check("post_rst_iss_ready", iss_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_no_stale", rf_wen, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
